// File: rtl/mdu_issue_ctrl_if.sv
// E-stage <-> MDU issue controller bundle: decoded MDU-class instruction in, control strobes out.
// Latency: n/a (wiring only).
// Backpressure: stall_e carries the hold request back to the E stage.
interface mdu_issue_ctrl_if;
    // E-stage side
    logic       clr;
    logic       e_valid;
    logic       e_md_start;
    logic [3:0] e_md_op;
    logic [1:0] e_mt;
    logic       e_mf;

    // Controller side
    logic       mdu_start;
    logic [3:0] mdu_op;
    logic [1:0] mthilo_we;
    logic       hilo_we;
    logic       busy;
    logic       stall_e;
    logic       op_err;

    // Pipeline / decode side drives the instruction and flush
    modport master (
        output clr,
        output e_valid,
        output e_md_start,
        output e_md_op,
        output e_mt,
        output e_mf,
        input  mdu_start,
        input  mdu_op,
        input  mthilo_we,
        input  hilo_we,
        input  busy,
        input  stall_e,
        input  op_err
    );

    // Issue controller consumes the instruction and produces the strobes
    modport slave (
        input  clr,
        input  e_valid,
        input  e_md_start,
        input  e_md_op,
        input  e_mt,
        input  e_mf,
        output mdu_start,
        output mdu_op,
        output mthilo_we,
        output hilo_we,
        output busy,
        output stall_e,
        output op_err
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// MDU issue/hazard controller: starts mult/div ops, times their latency, pulses HI/LO write-back.
// Latency: start strobe same cycle as accept; hilo_we LAT+1 cycles after start; re-accept at LAT+2.
// Backpressure: stall_e holds any MDU/MT/MF instruction in E while an op is in flight.
module mdu_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           reset,
    mdu_issue_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    // Counter reload values: RUN lasts exactly LAT cycles, counting LAT-1 down to 0.
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_LAT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_kill;
    logic w_idle;
    logic w_accept;
    logic w_op_legal;
    logic w_is_div;
    logic w_start;
    logic w_mt_req;
    logic w_mt_acc;
    logic w_mdu_instr;

    // Reset acts like a flush on the combinational strobes so nothing leaks out while it is held.
    assign w_kill      = bus.clr | reset;
    assign w_idle      = (r_state == IDLE);
    assign w_accept    = bus.e_valid & ~w_kill & w_idle;
    assign w_op_legal  = (bus.e_md_op <= 4'd7);
    assign w_is_div    = (bus.e_md_op == 4'd2) | (bus.e_md_op == 4'd3);
    assign w_start     = w_accept & bus.e_md_start & w_op_legal;
    assign w_mt_req    = (bus.e_mt != 2'b00);
    // A start and an MT in the same instruction: the start wins and HI/LO is not written directly.
    assign w_mt_acc    = w_accept & ~bus.e_md_start & w_mt_req;
    assign w_mdu_instr = bus.e_md_start | w_mt_req | bus.e_mf;

    assign bus.mdu_start = w_start;
    assign bus.mdu_op    = w_start ? bus.e_md_op : 4'd0;
    assign bus.mthilo_we = w_mt_acc ? bus.e_mt : 2'b00;
    assign bus.op_err    = w_accept & bus.e_md_start & ~w_op_legal;
    // busy comes from registered state only; non-MDU instructions never stall.
    assign bus.busy      = ~w_idle;
    assign bus.stall_e   = bus.e_valid & ~w_idle & w_mdu_instr & ~w_kill;
    // A flush landing on the WB cycle drops the commit: no partial write-back.
    assign bus.hilo_we   = (r_state == WB) & ~w_kill;

    // Issue FSM: IDLE accepts, RUN counts the op latency, WB is the single commit cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (bus.clr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= RUN;
                        r_cnt   <= w_is_div ? DIV_LD : MULT_LD;
                    end
                end
                RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= WB;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                WB: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
